// File: rtl/mt_branch_resolve_if.sv
// Execute-stage branch resolution bus: decoded control/operands in, PC-file redirect,
// link value and per-thread fault state out.
interface mt_branch_resolve_if #(
  parameter int NUM_THREADS   = 8,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  localparam int BITS_THREADS = $clog2(NUM_THREADS);

  logic                     valid_e;
  logic [BITS_THREADS-1:0]  tid_e;
  logic                     is_branch_e;
  logic                     is_jal_e;
  logic                     is_jalr_e;
  logic [2:0]               funct3_e;
  logic [DATA_WIDTH-1:0]    rs1_e;
  logic [DATA_WIDTH-1:0]    rs2_e;
  logic [ADDRESS_WIDTH-1:0] pc_e;
  logic [ADDRESS_WIDTH-1:0] imm_e;

  logic                     pc_src_e;
  logic [BITS_THREADS-1:0]  branch_tid_e;
  logic [ADDRESS_WIDTH-1:0] pc_target_e;
  logic [ADDRESS_WIDTH-1:0] link_e;

  logic [NUM_THREADS-1:0]   fault_mask;
  logic [NUM_THREADS-1:0]   fault_clr;
  logic [BITS_THREADS-1:0]  fault_tid;
  logic [ADDRESS_WIDTH-1:0] fault_addr;

  modport master (
    output valid_e, tid_e, is_branch_e, is_jal_e, is_jalr_e, funct3_e,
           rs1_e, rs2_e, pc_e, imm_e, fault_clr, fault_tid,
    input  pc_src_e, branch_tid_e, pc_target_e, link_e, fault_mask, fault_addr
  );

  modport slave (
    input  valid_e, tid_e, is_branch_e, is_jal_e, is_jalr_e, funct3_e,
           rs1_e, rs2_e, pc_e, imm_e, fault_clr, fault_tid,
    output pc_src_e, branch_tid_e, pc_target_e, link_e, fault_mask, fault_addr
  );
endinterface

// File: rtl/mt_branch_resolve.sv
// Resolves branches/JAL/JALR for the thread in execute, emits a one-cycle registered
// redirect, and quarantines threads that take a misaligned target until cleared.
module mt_branch_resolve #(
  parameter int NUM_THREADS   = 8,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input logic clk,
  input logic rst,
  mt_branch_resolve_if.slave bus
);
  localparam int BITS_THREADS = $clog2(NUM_THREADS);

  logic [NUM_THREADS-1:0]   fault_q;
  logic [ADDRESS_WIDTH-1:0] fault_addr_q [NUM_THREADS];

  logic                     legal, br, jal, jalr, cond;
  logic                     quarantined, take, misaligned, redirect, link_en;
  logic [ADDRESS_WIDTH-1:0] target;

  // Non-one-hot control combinations collapse to "no control transfer".
  assign legal = $onehot0({bus.is_branch_e, bus.is_jal_e, bus.is_jalr_e});
  assign br    = legal & bus.is_branch_e;
  assign jal   = legal & bus.is_jal_e;
  assign jalr  = legal & bus.is_jalr_e;

  always_comb begin
    cond = 1'b0;
    case (bus.funct3_e)
      3'b000:  cond = (bus.rs1_e == bus.rs2_e);
      3'b001:  cond = (bus.rs1_e != bus.rs2_e);
      3'b100:  cond = ($signed(bus.rs1_e) <  $signed(bus.rs2_e));
      3'b101:  cond = ($signed(bus.rs1_e) >= $signed(bus.rs2_e));
      3'b110:  cond = (bus.rs1_e <  bus.rs2_e);
      3'b111:  cond = (bus.rs1_e >= bus.rs2_e);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    if (jalr) target = (ADDRESS_WIDTH'(bus.rs1_e) + bus.imm_e) & ~ADDRESS_WIDTH'(1);
    else      target = bus.pc_e + bus.imm_e;
  end

  // Quarantine uses the registered mask, so a fault bites from the next cycle on.
  assign quarantined = fault_q[bus.tid_e];
  assign take        = bus.valid_e & ~quarantined & (jal | jalr | (br & cond));
  assign misaligned  = take & target[1];
  assign redirect    = take & ~target[1];
  assign link_en     = bus.valid_e & ~quarantined & (jal | jalr);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pc_src_e     <= 1'b0;
      bus.branch_tid_e <= '0;
      bus.pc_target_e  <= '0;
      bus.link_e       <= '0;
    end else begin
      bus.pc_src_e <= redirect;
      if (redirect) begin
        bus.branch_tid_e <= bus.tid_e;
        bus.pc_target_e  <= target;
      end
      if (link_en) bus.link_e <= bus.pc_e + ADDRESS_WIDTH'(4);
    end
  end

  // Per-thread fault slot; a new fault outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= '0;
      for (int t = 0; t < NUM_THREADS; t++) fault_addr_q[t] <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (misaligned && (bus.tid_e == BITS_THREADS'(t))) begin
          fault_q[t]      <= 1'b1;
          fault_addr_q[t] <= target;
        end else if (bus.fault_clr[t]) begin
          fault_q[t] <= 1'b0;
        end
      end
    end
  end

  assign bus.fault_mask = fault_q;
  assign bus.fault_addr = fault_addr_q[bus.fault_tid];
endmodule

// File: tb/tb_mt_branch_resolve.sv
// Directed bench for mt_branch_resolve: inputs change on negedge, outputs checked on
// the following negedge against hand-computed values.
module tb_mt_branch_resolve;
  logic clk, rst;
  int   n_chk, n_fail;

  mt_branch_resolve_if #(.NUM_THREADS(8), .ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mt_branch_resolve #(.NUM_THREADS(8), .ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (!$onehot0({bus.is_branch_e, bus.is_jal_e, bus.is_jalr_e}))
      $error("control flags not one-hot");

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // kind: 0 branch, 1 jal, 2 jalr
  task automatic issue(input int tid, input int kind, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] imm);
    bus.valid_e     = 1'b1;
    bus.tid_e       = 3'(tid);
    bus.is_branch_e = (kind == 0);
    bus.is_jal_e    = (kind == 1);
    bus.is_jalr_e   = (kind == 2);
    bus.funct3_e    = f3;
    bus.rs1_e       = rs1;
    bus.rs2_e       = rs2;
    bus.pc_e        = pc;
    bus.imm_e       = imm;
  endtask

  task automatic idle();
    bus.valid_e     = 1'b0;
    bus.is_branch_e = 1'b0;
    bus.is_jal_e    = 1'b0;
    bus.is_jalr_e   = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    idle();
    bus.tid_e = '0; bus.funct3_e = '0; bus.rs1_e = '0; bus.rs2_e = '0;
    bus.pc_e = '0; bus.imm_e = '0; bus.fault_clr = '0; bus.fault_tid = '0;
    step(); step();
    chk("rst_pc_src", 64'(bus.pc_src_e), 0);
    chk("rst_tid", 64'(bus.branch_tid_e), 0);
    chk("rst_target", 64'(bus.pc_target_e), 0);
    chk("rst_link", 64'(bus.link_e), 0);
    chk("rst_mask", 64'(bus.fault_mask), 0);
    chk("rst_faddr", 64'(bus.fault_addr), 0);
    rst = 1'b0;

    // BEQ taken, then pulse drops and target holds
    issue(3, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20); step(); idle();
    chk("beq_src", 64'(bus.pc_src_e), 1);
    chk("beq_tid", 64'(bus.branch_tid_e), 3);
    chk("beq_tgt", 64'(bus.pc_target_e), 64'h120);
    step();
    chk("beq_pulse", 64'(bus.pc_src_e), 0);
    chk("beq_hold", 64'(bus.pc_target_e), 64'h120);

    // Signed vs unsigned compare, reserved funct3
    issue(1, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10); step(); idle();
    chk("blt_src", 64'(bus.pc_src_e), 1);
    chk("blt_tgt", 64'(bus.pc_target_e), 64'h210);
    issue(1, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40); step(); idle();
    chk("bltu_src", 64'(bus.pc_src_e), 0);
    chk("bltu_hold", 64'(bus.pc_target_e), 64'h210);
    issue(1, 0, 3'b010, 32'd7, 32'd7, 32'h200, 32'h40); step(); idle();
    chk("f3_010_src", 64'(bus.pc_src_e), 0);
    issue(4, 0, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h8); step(); idle();
    chk("bgeu_src", 64'(bus.pc_src_e), 1);
    chk("bgeu_tgt", 64'(bus.pc_target_e), 64'h408);
    issue(4, 0, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'hC); step(); idle();
    chk("bge_src", 64'(bus.pc_src_e), 0);

    // JALR clears bit 0, registers link
    issue(5, 2, 3'b000, 32'h2001, 32'd0, 32'h40, 32'h4); step(); idle();
    chk("jalr_src", 64'(bus.pc_src_e), 1);
    chk("jalr_tid", 64'(bus.branch_tid_e), 5);
    chk("jalr_tgt", 64'(bus.pc_target_e), 64'h2004);
    chk("jalr_link", 64'(bus.link_e), 64'h44);

    // Misaligned JAL: fault, no redirect, link still written
    issue(2, 1, 3'b000, 32'd0, 32'd0, 32'h100, 32'h6); step(); idle();
    bus.fault_tid = 3'd2;
    chk("mis_src", 64'(bus.pc_src_e), 0);
    chk("mis_mask", 64'(bus.fault_mask), 64'h04);
    chk("mis_faddr", 64'(bus.fault_addr), 64'h106);
    chk("mis_link", 64'(bus.link_e), 64'h104);
    chk("mis_tgt_hold", 64'(bus.pc_target_e), 64'h2004);
    issue(2, 0, 3'b000, 32'd5, 32'd5, 32'h300, 32'h8); step(); idle();
    chk("quar_src", 64'(bus.pc_src_e), 0);
    issue(2, 1, 3'b000, 32'd0, 32'd0, 32'h500, 32'h8); step(); idle();
    chk("quar_link", 64'(bus.link_e), 64'h104);
    bus.fault_clr = 8'h04; step(); bus.fault_clr = 8'h00;
    chk("clr_mask", 64'(bus.fault_mask), 0);
    issue(2, 0, 3'b000, 32'd5, 32'd5, 32'h300, 32'h8); step(); idle();
    chk("unq_src", 64'(bus.pc_src_e), 1);
    chk("unq_tid", 64'(bus.branch_tid_e), 2);
    chk("unq_tgt", 64'(bus.pc_target_e), 64'h308);

    // Same-cycle clear and new fault: set wins
    bus.fault_clr = 8'h40;
    issue(6, 1, 3'b000, 32'd0, 32'd0, 32'h20, 32'h2); step(); idle();
    bus.fault_clr = 8'h00; bus.fault_tid = 3'd6;
    chk("setwin_mask", 64'(bus.fault_mask), 64'h40);
    chk("setwin_faddr", 64'(bus.fault_addr), 64'h22);

    // Wrap-around JAL
    issue(7, 1, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h8); step(); idle();
    chk("wrap_src", 64'(bus.pc_src_e), 1);
    chk("wrap_tgt", 64'(bus.pc_target_e), 64'h4);
    chk("wrap_link", 64'(bus.link_e), 64'h0);

    // Back-to-back redirects, then reset during a third take
    issue(0, 0, 3'b000, 32'd1, 32'd1, 32'h1000, 32'h10); step();
    chk("b2b0_src", 64'(bus.pc_src_e), 1);
    chk("b2b0_tid", 64'(bus.branch_tid_e), 0);
    chk("b2b0_tgt", 64'(bus.pc_target_e), 64'h1010);
    issue(1, 1, 3'b000, 32'd0, 32'd0, 32'h2000, 32'h40); step();
    chk("b2b1_src", 64'(bus.pc_src_e), 1);
    chk("b2b1_tid", 64'(bus.branch_tid_e), 1);
    chk("b2b1_tgt", 64'(bus.pc_target_e), 64'h2040);
    issue(2, 0, 3'b000, 32'd1, 32'd1, 32'h3000, 32'h0);
    rst = 1'b1; step();
    rst = 1'b0; idle();
    chk("mrst_src", 64'(bus.pc_src_e), 0);
    chk("mrst_tid", 64'(bus.branch_tid_e), 0);
    chk("mrst_tgt", 64'(bus.pc_target_e), 0);
    chk("mrst_link", 64'(bus.link_e), 0);
    chk("mrst_mask", 64'(bus.fault_mask), 0);
    chk("mrst_faddr", 64'(bus.fault_addr), 0);
    step();
    chk("post_rst_src", 64'(bus.pc_src_e), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
